score_combo_tracker: RTL and testbench

//   Multi-channel score keeper. Each channel is one hand/lane and has a hit input and a miss input.

---
 rtl/score_combo_tracker.sv | 198 +++++++++++++++++++
 tb/tb_score_combo_tracker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_combo_tracker.sv
// Per-channel hit/miss scoring with a combo multiplier, plus a framed valid/ready
// byte snapshot of all scores: header 0xA5, score bytes, XOR checksum of the score bytes.
module score_combo_tracker #(
  parameter int NUM_CH     = 2,
  parameter int SCORE_W    = 8,
  parameter int COMBO_W    = 6,
  parameter int BONUS_STEP = 8,
  parameter int MAX_MULT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [NUM_CH-1:0]           hit,
  input  logic [NUM_CH-1:0]           miss,
  output logic [NUM_CH*SCORE_W-1:0]   score_flat,
  output logic [NUM_CH*COMBO_W-1:0]   combo_flat,
  input  logic                        snap_req,
  output logic                        busy,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready
);

  localparam int B     = (SCORE_W + 7) / 8;
  localparam int NB    = NUM_CH * B;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;
  localparam logic [31:0] COMBO_MAX = (32'd1 << COMBO_W) - 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t              state_r;
  logic [NUM_CH-1:0]   prev_hit_r;
  logic [NUM_CH-1:0]   prev_miss_r;
  logic [NUM_CH-1:0]   hit_edge_s;
  logic [NUM_CH-1:0]   miss_edge_s;
  logic [SCORE_W-1:0]  score_r      [NUM_CH];
  logic [COMBO_W-1:0]  combo_r      [NUM_CH];
  logic [SCORE_W-1:0]  score_next_s [NUM_CH];
  logic [COMBO_W-1:0]  combo_next_s [NUM_CH];
  logic [SCORE_W-1:0]  shadow_r     [NUM_CH];
  logic [NB*8-1:0]     shadow_pad_s;
  logic [7:0]          snap_bytes_s [NB];
  logic [7:0]          csum_r;
  logic [IDX_W-1:0]    idx_r;
  logic                last_byte_s;
  logic [7:0]          next_byte_s;

  // Points for a hit, taken from the combo count before this hit's increment.
  function automatic logic [31:0] hit_points(input logic [COMBO_W-1:0] combo);
    logic [31:0] p;
    p = 32'd1 + (32'(combo) / 32'(BONUS_STEP));
    if (p > 32'(MAX_MULT)) begin
      hit_points = 32'(MAX_MULT);
    end else begin
      hit_points = p;
    end
  endfunction

  assign hit_edge_s  = hit & ~prev_hit_r;
  assign miss_edge_s = miss & ~prev_miss_r;

  // Saturating next score/combo for a hit on each channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if ((32'(score_r[i]) + hit_points(combo_r[i])) > SCORE_MAX) begin
        score_next_s[i] = SCORE_MAX[SCORE_W-1:0];
      end else begin
        score_next_s[i] = score_r[i] + SCORE_W'(hit_points(combo_r[i]));
      end
      if (32'(combo_r[i]) == COMBO_MAX) begin
        combo_next_s[i] = combo_r[i];
      end else begin
        combo_next_s[i] = combo_r[i] + COMBO_W'(1'b1);
      end
    end
  end

  // Flatten per-channel registers onto the output buses.
  always_comb begin
    score_flat = '0;
    combo_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      score_flat[i*SCORE_W +: SCORE_W] = score_r[i];
      combo_flat[i*COMBO_W +: COMBO_W] = combo_r[i];
    end
  end

  // Zero-padded byte view of the shadowed scores, channel 0 / LSB byte first.
  always_comb begin
    shadow_pad_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_pad_s[i*B*8 +: SCORE_W] = shadow_r[i];
    end
    for (int k = 0; k < NB; k++) begin
      snap_bytes_s[k] = shadow_pad_s[k*8 +: 8];
    end
  end

  assign last_byte_s = (idx_r == IDX_W'(NB - 1));
  assign next_byte_s = last_byte_s ? 8'h00 : snap_bytes_s[idx_r + IDX_W'(1'b1)];

  // Edge tracking and score/combo update; clr beats miss, miss beats hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_hit_r  <= '0;
      prev_miss_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        score_r[i] <= '0;
        combo_r[i] <= '0;
      end
    end else begin
      prev_hit_r  <= hit;
      prev_miss_r <= miss;
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr) begin
          score_r[i] <= '0;
          combo_r[i] <= '0;
        end else if (miss_edge_s[i]) begin
          combo_r[i] <= '0;
        end else if (hit_edge_s[i]) begin
          score_r[i] <= score_next_s[i];
          combo_r[i] <= combo_next_s[i];
        end
      end
    end
  end

  // Snapshot framer; tx_data/tx_valid only move on a completed transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      csum_r   <= 8'h00;
      idx_r    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (snap_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
              shadow_r[i] <= score_r[i];
            end
            csum_r   <= 8'h00;
            idx_r    <= '0;
            tx_data  <= 8'hA5;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state_r  <= HDR;
          end
        end
        HDR: begin
          if (tx_ready) begin
            tx_data <= snap_bytes_s[0];
            idx_r   <= '0;
            state_r <= DATA;
          end
        end
        DATA: begin
          if (tx_ready) begin
            csum_r <= csum_r ^ tx_data;
            if (last_byte_s) begin
              tx_data <= csum_r ^ tx_data;
              state_r <= CSUM;
            end else begin
              tx_data <= next_byte_s;
              idx_r   <= idx_r + IDX_W'(1'b1);
            end
          end
        end
        CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_combo_tracker.sv
// Directed bench for score_combo_tracker: a small scoring model for the score/combo
// outputs and a byte queue of expected snapshot frames drained as the DUT transmits.
module tb_score_combo_tracker;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       clr      = 1'b0;
  logic [1:0] hit      = 2'b00;
  logic [1:0] miss     = 2'b00;
  logic       snap_req = 1'b0;
  logic       tx_ready = 1'b0;
  logic [15:0] score_flat;
  logic [11:0] combo_flat;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int checks   = 0;
  int failures = 0;
  int m_score [2];
  int m_combo [2];
  logic [7:0] sb [$];

  score_combo_tracker #(
    .NUM_CH(2), .SCORE_W(8), .COMBO_W(6), .BONUS_STEP(8), .MAX_MULT(4)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .hit(hit), .miss(miss),
    .score_flat(score_flat), .combo_flat(combo_flat),
    .snap_req(snap_req), .busy(busy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_score[c] = 0;
      m_combo[c] = 0;
    end
  endtask

  task automatic model_apply(input logic [1:0] h, input logic [1:0] m);
    int p;
    for (int c = 0; c < 2; c++) begin
      if (m[c]) begin
        m_combo[c] = 0;
      end else if (h[c]) begin
        p = 1 + m_combo[c] / 8;
        if (p > 4) p = 4;
        m_score[c] = (m_score[c] + p > 255) ? 255 : m_score[c] + p;
        m_combo[c] = (m_combo[c] == 63) ? 63 : m_combo[c] + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_score0"}, {24'h0, score_flat[7:0]},  m_score[0]);
    check({tag, "_combo0"}, {26'h0, combo_flat[5:0]},  m_combo[0]);
    check({tag, "_score1"}, {24'h0, score_flat[15:8]}, m_score[1]);
    check({tag, "_combo1"}, {26'h0, combo_flat[11:6]}, m_combo[1]);
  endtask

  task automatic pulse(input logic [1:0] h, input logic [1:0] m);
    @(negedge clk);
    hit  = h;
    miss = m;
    model_apply(h, m);
    @(negedge clk);
    hit  = 2'b00;
    miss = 2'b00;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  // Scores built from isolated hits (miss after each) so every hit is worth one point.
  task automatic set_scores(input int a, input int b);
    int n;
    do_clr();
    n = (a > b) ? a : b;
    for (int i = 0; i < n; i++) begin
      pulse({(i < b) ? 1'b1 : 1'b0, (i < a) ? 1'b1 : 1'b0}, 2'b00);
      pulse(2'b00, 2'b11);
    end
  endtask

  task automatic push_frame();
    logic [7:0] s0;
    logic [7:0] s1;
    s0 = 8'(m_score[0]);
    s1 = 8'(m_score[1]);
    sb.push_back(8'hA5);
    sb.push_back(s0);
    sb.push_back(s1);
    sb.push_back(s0 ^ s1);
  endtask

  task automatic start_snap();
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    check("busy_on", {31'h0, busy}, 32'd1);
  endtask

  // Drain the expected-byte queue; stall holds tx_ready low that many cycles per byte.
  task automatic run_stream(input int stall, input bit disturb);
    int held;
    int cycles;
    int xfers;
    held = 0; cycles = 0; xfers = 0;
    while (sb.size() != 0 && cycles < 100) begin
      clr      = 1'b0;
      snap_req = 1'b0;
      check("tx_valid", {31'h0, tx_valid}, 32'd1);
      if (held < stall) begin
        tx_ready = 1'b0;
        check("hold_data", {24'h0, tx_data}, {24'h0, sb[0]});
        held++;
      end else begin
        tx_ready = 1'b1;
        check("byte", {24'h0, tx_data}, {24'h0, sb.pop_front()});
        held = 0;
        xfers++;
        if (disturb && xfers == 1) begin
          clr      = 1'b1;
          snap_req = 1'b1;
          model_clear();
        end
      end
      @(negedge clk);
      cycles++;
    end
    tx_ready = 1'b0;
    clr      = 1'b0;
    snap_req = 1'b0;
    check("stream_done", sb.size(), 32'd0);
    check("busy_end", {31'h0, busy}, 32'd0);
    check("valid_end", {31'h0, tx_valid}, 32'd0);
  endtask

  initial begin
    model_clear();
    #1 rst = 1'b0;
    #2;
    check("rst_score", {16'h0, score_flat}, 32'd0);
    check("rst_combo", {20'h0, combo_flat}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_valid", {31'h0, tx_valid}, 32'd0);
    check("rst_data", {24'h0, tx_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1: eight single-point hits, then the first doubled hit
    repeat (8) pulse(2'b01, 2'b00);
    check("t1_score0_8", {24'h0, score_flat[7:0]}, 32'd8);
    check("t1_combo0_8", {26'h0, combo_flat[5:0]}, 32'd8);
    pulse(2'b01, 2'b00);
    check("t1_score0_10", {24'h0, score_flat[7:0]}, 32'd10);
    check("t1_combo0_9", {26'h0, combo_flat[5:0]}, 32'd9);
    check("t1_ch1_idle", {16'h0, score_flat[15:8], 2'b00, combo_flat[11:6]}, 32'd0);

    // 2: a held level scores once; miss breaks the combo only
    @(negedge clk);
    hit = 2'b10;
    model_apply(2'b10, 2'b00);
    repeat (20) @(negedge clk);
    hit = 2'b00;
    check("t2_score1", {24'h0, score_flat[15:8]}, 32'd1);
    check("t2_combo1", {26'h0, combo_flat[11:6]}, 32'd1);
    pulse(2'b00, 2'b10);
    check("t2_miss_combo1", {26'h0, combo_flat[11:6]}, 32'd0);
    check("t2_miss_score1", {24'h0, score_flat[15:8]}, 32'd1);

    // 3: saturation of score and combo
    while (m_score[0] < 250) pulse(2'b01, 2'b00);
    repeat (10) pulse(2'b01, 2'b00);
    check("t3_score_sat", {24'h0, score_flat[7:0]}, 32'd255);
    while (m_combo[0] < 63) pulse(2'b01, 2'b00);
    repeat (3) pulse(2'b01, 2'b00);
    check("t3_combo_sat", {26'h0, combo_flat[5:0]}, 32'd63);
    check("t3_score_hold", {24'h0, score_flat[7:0]}, 32'd255);
    check_model("t3");

    // 4: simultaneous hit+miss, then clr against hits
    do_clr();
    check("t4_clr", {16'h0, score_flat}, 32'd0);
    repeat (2) pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    repeat (5) pulse(2'b01, 2'b00);
    pulse(2'b10, 2'b00);
    check("t4_score0_7", {24'h0, score_flat[7:0]}, 32'd7);
    check("t4_combo0_5", {26'h0, combo_flat[5:0]}, 32'd5);
    pulse(2'b01, 2'b01);
    check("t4_hm_score0", {24'h0, score_flat[7:0]}, 32'd7);
    check("t4_hm_combo0", {26'h0, combo_flat[5:0]}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    hit = 2'b11;
    @(negedge clk);
    clr = 1'b0;
    hit = 2'b00;
    model_clear();
    check("t4_clrhit_score", {16'h0, score_flat}, 32'd0);
    check("t4_clrhit_combo", {20'h0, combo_flat}, 32'd0);

    // 5: snapshot at full rate, then with back-pressure
    set_scores(8'h12, 8'h34);
    check_model("t5_setup");
    push_frame();
    start_snap();
    run_stream(0, 1'b0);
    push_frame();
    start_snap();
    run_stream(3, 1'b0);

    // 6: clr and snap_req during a stream
    push_frame();
    start_snap();
    run_stream(0, 1'b1);
    check_model("t6_after_clr");
    repeat (3) begin
      @(negedge clk);
      check("t6_no_requeue", {31'h0, tx_valid}, 32'd0);
    end

    // 6: asynchronous reset after two transferred bytes
    set_scores(3, 5);
    start_snap();
    tx_ready = 1'b1;
    check("t6_hdr", {24'h0, tx_data}, 32'hA5);
    @(negedge clk);
    check("t6_b0", {24'h0, tx_data}, 32'h03);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_abort_valid", {31'h0, tx_valid}, 32'd0);
    check("t6_abort_data", {24'h0, tx_data}, 32'd0);
    check("t6_abort_busy", {31'h0, busy}, 32'd0);
    check("t6_abort_score", {16'h0, score_flat}, 32'd0);
    check("t6_abort_combo", {20'h0, combo_flat}, 32'd0);
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    push_frame();
    start_snap();
    run_stream(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
